// File: rtl/controller_reader_if.sv
// Bus bundle for controller_reader: CPU-side poll/read signals plus the pad serial lines.
// The slave modport is the reader itself; the master modport is whatever drives it.
interface controller_reader_if #(
    parameter int NUM_CONTROLLERS = 2
) ();
    logic                       poll_start;
    logic [NUM_CONTROLLERS-1:0] ctrl_data_B;
    logic                       ctrl_latch;
    logic                       ctrl_clk;
    logic                       cpu_address;
    logic                       SELECT_controller;
    logic [7:0]                 data_out;
    logic                       busy;
    logic                       valid;

    modport master (
        output poll_start, ctrl_data_B, cpu_address, SELECT_controller,
        input  ctrl_latch, ctrl_clk, data_out, busy, valid
    );

    modport slave (
        input  poll_start, ctrl_data_B, cpu_address, SELECT_controller,
        output ctrl_latch, ctrl_clk, data_out, busy, valid
    );
endinterface

// File: rtl/controller_reader.sv
// Serial reader for NES-style gamepads: latch, clock out 8 bits per pad, publish atomically.
// Optional macro CONTROLLER_DEBOUNCE_EN: a new byte is published only after two identical polls.
module controller_reader #(
    parameter int NUM_CONTROLLERS = 2,
    parameter int HALF_PERIOD     = 6
) (
    input logic                clk_12_5875,
    input logic                rst,
    controller_reader_if.slave bus
);

    localparam int TIMER_W = $clog2(2 * HALF_PERIOD);
    localparam logic [TIMER_W-1:0] HALF_LAST  = TIMER_W'(HALF_PERIOD - 1);
    localparam logic [TIMER_W-1:0] LATCH_LAST = TIMER_W'(2 * HALF_PERIOD - 1);

    typedef enum logic [2:0] {IDLE, LATCH, LOW, HIGH, DONE} state_e;

    state_e                           state_q, state_d;
    logic [TIMER_W-1:0]               timer_q, timer_d;
    logic [2:0]                       bit_q, bit_d;
    logic [NUM_CONTROLLERS-1:0][7:0]  shift_q, shift_d;
    logic [NUM_CONTROLLERS-1:0][7:0]  shadow_q, shadow_d;
    logic                             ctrl_latch_q, ctrl_latch_d;
    logic                             ctrl_clk_q, ctrl_clk_d;
    logic                             busy_q, busy_d;
    logic                             valid_q, valid_d;
`ifdef CONTROLLER_DEBOUNCE_EN
    logic [NUM_CONTROLLERS-1:0][7:0]  candidate_q, candidate_d;
    logic                             confirmed;
`endif
    logic [7:0]                       pad_byte [2];

    always_ff @(posedge clk_12_5875) begin
        if (rst) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            shadow_q     <= '0;
            ctrl_latch_q <= 1'b0;
            ctrl_clk_q   <= 1'b0;
            busy_q       <= 1'b0;
            valid_q      <= 1'b0;
`ifdef CONTROLLER_DEBOUNCE_EN
            candidate_q  <= '0;
`endif
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            shadow_q     <= shadow_d;
            ctrl_latch_q <= ctrl_latch_d;
            ctrl_clk_q   <= ctrl_clk_d;
            busy_q       <= busy_d;
            valid_q      <= valid_d;
`ifdef CONTROLLER_DEBOUNCE_EN
            candidate_q  <= candidate_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.poll_start) state_d = LATCH;
            LATCH:   if (timer_q == LATCH_LAST) state_d = LOW;
            LOW:     if (timer_q == HALF_LAST) state_d = HIGH;
            HIGH:    if (timer_q == HALF_LAST) state_d = (bit_q == 3'd7) ? DONE : LOW;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Pad lines and busy are registered from the next state so they line up with the state itself.
    always_comb begin
        timer_d  = timer_q + 1'b1;
        if (state_d != state_q || state_q == IDLE) timer_d = '0;
        bit_d    = bit_q;
        shift_d  = shift_q;
        shadow_d = shadow_q;
        valid_d  = valid_q;
`ifdef CONTROLLER_DEBOUNCE_EN
        candidate_d = candidate_q;
        confirmed   = 1'b1;
`endif
        case (state_q)
            IDLE: if (state_d == LATCH) bit_d = '0;
            LOW: begin
                if (timer_q == HALF_LAST) begin
                    for (int n = 0; n < NUM_CONTROLLERS; n++) shift_d[n][bit_q] = ~bus.ctrl_data_B[n];
                end
            end
            HIGH: if (timer_q == HALF_LAST && bit_q != 3'd7) bit_d = bit_q + 1'b1;
            DONE: begin
`ifdef CONTROLLER_DEBOUNCE_EN
                for (int n = 0; n < NUM_CONTROLLERS; n++) begin
                    if (shift_q[n] == candidate_q[n]) shadow_d[n] = shift_q[n];
                    else confirmed = 1'b0;
                end
                candidate_d = shift_q;
                if (confirmed) valid_d = 1'b1;
`else
                shadow_d = shift_q;
                valid_d  = 1'b1;
`endif
            end
            default: ;
        endcase
        ctrl_latch_d = (state_d == LATCH);
        ctrl_clk_d   = (state_d == HIGH);
        busy_d       = (state_d == LATCH) || (state_d == LOW) || (state_d == HIGH);
    end

    // Absent pads read back as zero rather than aliasing onto a real one.
    for (genvar g = 0; g < 2; g++) begin : g_pad_byte
        if (g < NUM_CONTROLLERS) begin : g_present
            assign pad_byte[g] = shadow_q[g];
        end else begin : g_absent
            assign pad_byte[g] = 8'h00;
        end
    end

    assign bus.data_out   = bus.SELECT_controller ? pad_byte[bus.cpu_address] : 8'h00;
    assign bus.ctrl_latch = ctrl_latch_q;
    assign bus.ctrl_clk   = ctrl_clk_q;
    assign bus.busy       = busy_q;
    assign bus.valid      = valid_q;

endmodule

// File: tb/tb_controller_reader.sv
// Directed bench for controller_reader with two behavioural 4021-style pads.
// Pad patterns are given as "pressed" bytes; the pad model drives their active-low form.
module tb_controller_reader;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    controller_reader_if #(.NUM_CONTROLLERS(2)) bus ();

    controller_reader #(
        .NUM_CONTROLLERS(2),
        .HALF_PERIOD(6)
    ) dut (
        .clk_12_5875(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [7:0] padPressed [2];
    logic [7:0] padShift   [2];

    // Pads parallel-load on latch and shift toward bit 0 on each rising ctrl_clk.
    always @(posedge bus.ctrl_latch or posedge bus.ctrl_clk) begin
        for (int n = 0; n < 2; n++) begin
            if (bus.ctrl_latch) padShift[n] = ~padPressed[n];
            else padShift[n] = {1'b1, padShift[n][7:1]};
        end
    end

    assign bus.ctrl_data_B = {padShift[1][0], padShift[0][0]};

    int checkCount = 0;
    int errorCount = 0;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    int         busyCount, latchCount, clkHighCount, clkRises;
    logic       busyFirst, validAtDone;
    logic [7:0] readMid, readDone, readAfter;

    // Runs one poll and records per-cycle observations; sample k is taken k+1 edges after the request edge.
    task automatic applyStimulus(input logic [7:0] p0, input logic [7:0] p1, input int extraPulseAt);
        logic prevClk;
        padPressed[0] = p0;
        padPressed[1] = p1;
        busyCount = 0; latchCount = 0; clkHighCount = 0; clkRises = 0;
        prevClk = 1'b0;
        @(negedge clk);
        bus.poll_start = 1'b1;
        for (int k = 0; k < 115; k++) begin
            @(negedge clk);
            bus.poll_start = (k == extraPulseAt);
            if (k == 0) busyFirst = bus.busy;
            busyCount    += int'(bus.busy);
            latchCount   += int'(bus.ctrl_latch);
            clkHighCount += int'(bus.ctrl_clk);
            if (bus.ctrl_clk && !prevClk) clkRises++;
            prevClk = bus.ctrl_clk;
            if (k == 50) readMid = bus.data_out;
            if (k == 108) begin
                readDone    = bus.data_out;
                validAtDone = bus.valid;
            end
            if (k == 109) readAfter = bus.data_out;
        end
        bus.poll_start = 1'b0;
    endtask

    task automatic readPad(input logic addr, output logic [7:0] value);
        bus.cpu_address = addr;
        #1;
        value = bus.data_out;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] rd;
        padShift[0] = 8'hFF;
        padShift[1] = 8'hFF;
        padPressed[0] = 8'h00;
        padPressed[1] = 8'h00;
        bus.poll_start = 1'b0;
        bus.cpu_address = 1'b0;
        bus.SELECT_controller = 1'b1;
        rst = 1'b1;

        // Reset held for three edges
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_latch", int'(bus.ctrl_latch), 0);
        checkOutput("rst_clk",   int'(bus.ctrl_clk), 0);
        checkOutput("rst_busy",  int'(bus.busy), 0);
        checkOutput("rst_valid", int'(bus.valid), 0);
        readPad(1'b0, rd); checkOutput("rst_data0", int'(rd), 0);
        readPad(1'b1, rd); checkOutput("rst_data1", int'(rd), 0);
        bus.cpu_address = 1'b0;
        rst = 1'b0;

`ifndef CONTROLLER_DEBOUNCE_EN
        // A pressed on pad0, nothing on pad1
        applyStimulus(8'h01, 8'h00, -1);
        checkOutput("p1_busy_rise",  int'(busyFirst), 1);
        checkOutput("p1_busy_len",   busyCount, 108);
        checkOutput("p1_latch_len",  latchCount, 12);
        checkOutput("p1_clk_high",   clkHighCount, 48);
        checkOutput("p1_clk_pulses", clkRises, 8);
        checkOutput("p1_valid_done", int'(validAtDone), 0);
        checkOutput("p1_read_after", int'(readAfter), 8'h01);
        checkOutput("p1_valid",      int'(bus.valid), 1);
        readPad(1'b1, rd); checkOutput("p1_data1", int'(rd), 8'h00);
        bus.cpu_address = 1'b0;

        // Right+Start, then deselected bus
        applyStimulus(8'h88, 8'h00, -1);
        readPad(1'b0, rd); checkOutput("p2_data0", int'(rd), 8'h88);
        bus.SELECT_controller = 1'b0;
        #1 checkOutput("p2_deselect", int'(bus.data_out), 8'h00);
        bus.SELECT_controller = 1'b1;

        // Reads during a poll keep the old byte until after DONE
        applyStimulus(8'h40, 8'h00, -1);
        checkOutput("p3_read_mid",   int'(readMid), 8'h88);
        checkOutput("p3_read_done",  int'(readDone), 8'h88);
        checkOutput("p3_read_after", int'(readAfter), 8'h40);

        // Second request 20 cycles in is dropped
        applyStimulus(8'h05, 8'h30, 20);
        checkOutput("p4_busy_len",   busyCount, 108);
        checkOutput("p4_clk_pulses", clkRises, 8);
        checkOutput("p4_latch_len",  latchCount, 12);
        checkOutput("p4_busy_end",   int'(bus.busy), 0);
        readPad(1'b0, rd); checkOutput("p4_data0", int'(rd), 8'h05);
        readPad(1'b1, rd); checkOutput("p4_data1", int'(rd), 8'h30);
        bus.cpu_address = 1'b0;

        // Reset asserted 50 cycles into a poll
        padPressed[0] = 8'h7E;
        padPressed[1] = 8'h81;
        @(negedge clk);
        bus.poll_start = 1'b1;
        @(negedge clk);
        bus.poll_start = 1'b0;
        repeat (50) @(negedge clk);
        checkOutput("r_busy_before", int'(bus.busy), 1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("r_latch", int'(bus.ctrl_latch), 0);
        checkOutput("r_clk",   int'(bus.ctrl_clk), 0);
        checkOutput("r_busy",  int'(bus.busy), 0);
        checkOutput("r_valid", int'(bus.valid), 0);
        readPad(1'b0, rd); checkOutput("r_data0", int'(rd), 0);
        readPad(1'b1, rd); checkOutput("r_data1", int'(rd), 0);
        bus.cpu_address = 1'b0;
        rst = 1'b0;

        // Reader recovers cleanly after the aborted poll
        applyStimulus(8'h7E, 8'h81, -1);
        checkOutput("rr_read_after", int'(readAfter), 8'h7E);
        readPad(1'b1, rd); checkOutput("rr_data1", int'(rd), 8'h81);
        bus.cpu_address = 1'b0;
`else
        // Debounced: a change must appear in two consecutive polls
        applyStimulus(8'h01, 8'h00, -1);
        checkOutput("d1_data0", int'(readAfter), 8'h00);
        checkOutput("d1_valid", int'(bus.valid), 0);
        applyStimulus(8'h01, 8'h00, -1);
        checkOutput("d2_data0", int'(readAfter), 8'h01);
        checkOutput("d2_valid", int'(bus.valid), 1);
        applyStimulus(8'h02, 8'h00, -1);
        checkOutput("d3_data0", int'(readAfter), 8'h01);
        applyStimulus(8'h04, 8'h00, -1);
        checkOutput("d4_data0", int'(readAfter), 8'h01);
        checkOutput("d4_busy_len", busyCount, 108);
`endif

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/controller_reader.md
Name: controller_reader

Overview:
- Serial reader for two NES-style shift-register gamepads attached to the console's controller port.
- On each poll request (normally the start of vblank), it pulses latch, clocks 8 bits out of each pad and captures them into shadow registers.
- The CPU reads the shadow registers through the address-decoded controller select, so the CPU never sees a half-shifted value.

Parameters:
- NUM_CONTROLLERS, 2, number of pads polled in parallel (1..2); selected by cpu_address[0].
- HALF_PERIOD, 6, clk_12_5875 cycles per half period of ctrl_latch and ctrl_clk (>=2).

Ports:
- clk_12_5875  input  1  system clock (12.5875 MHz).
- rst  input  1  synchronous, active-high reset.
- poll_start  input  1  single-cycle poll request.
- ctrl_data_B  input  NUM_CONTROLLERS  serial data from each pad; active-low means pressed.
- ctrl_latch  output  1  parallel-load strobe to the pads; active-high.
- ctrl_clk  output  1  shift clock to the pads; pads shift on the rising edge.
- cpu_address  input  1  controller index; this is CPU address bit 0.
- SELECT_controller  input  1  controller read select from the address bus.
- data_out  output  8  button byte for the selected pad.
- busy  output  1  high while a poll is in progress.
- valid  output  1  high once at least one poll has completed since reset.

Behaviour:
- Reset:
  - All outputs and state are set on a rising edge with rst=1 (synchronous): ctrl_latch=0, ctrl_clk=0, busy=0, valid=0, shadow registers=0, state=IDLE.
  - data_out=0.
- States: IDLE, LATCH, LOW, HIGH, DONE. A timer counts 0..HALF_PERIOD-1. A bit counter runs 0..7.
- IDLE:
  - If poll_start=1, go to LATCH: timer=0, bit=0, busy=1.
  - Otherwise remain in IDLE.
- LATCH:
  - ctrl_latch=1 for 2*HALF_PERIOD cycles, then go to LOW.
- LOW:
  - ctrl_clk=0 for HALF_PERIOD cycles.
  - On the last cycle, sample ~ctrl_data_B[n] into shift[n][bit].
  - Go to HIGH.
- HIGH:
  - ctrl_clk=1 for HALF_PERIOD cycles.
  - On the last cycle: if bit==7, go to DONE; otherwise bit+=1 and go to LOW.
  - The rising edge of ctrl_clk after bit 7 is harmless to the pad.
- DONE (1 cycle):
  - Copy shift[] into the shadow registers.
  - valid=1, busy=0.
  - Go to IDLE.
- Bit order, with 1 meaning pressed:
  - bit0=A, bit1=B, bit2=Select, bit3=Start.
  - bit4=Up, bit5=Down, bit6=Left, bit7=Right.
- Latency:
  - From the poll_start cycle to the shadow update is 2H+16H+1 cycles, where H=HALF_PERIOD.
  - With H=6 this is 109 cycles.
  - busy rises the cycle after poll_start.
- data_out (combinational):
  - When SELECT_controller=1, data_out = shadow[cpu_address].
  - Otherwise data_out = 0.
  - With NUM_CONTROLLERS=1, or when cpu_address selects an absent pad, data_out = 0.
- A poll_start while busy=1 is ignored. It is not queued.
- CPU reads during a poll return the previous shadow value. The update is atomic in DONE.
- A CPU read in the same cycle as DONE returns the old value. The new value is visible the next cycle.
- rst asserted mid-poll:
  - Aborts the poll and takes the full reset values above.
  - ctrl_latch and ctrl_clk drop the next cycle.
- ctrl_latch and ctrl_clk are driven directly from registers, so they are glitch-free.

Optional Feature:
- Macro: CONTROLLER_DEBOUNCE_EN.
- Defined:
  - Each pad has a candidate register.
  - In DONE, the shadow is updated only if the new sample equals the candidate from the previous poll. The candidate is always replaced by the new sample.
  - Result: a change needs two consecutive identical polls to appear.
  - valid rises after the first poll that is confirmed this way.
  - The candidate resets to 0.
- Undefined: the shadow is updated on every DONE, as described above.

Test Plan:
- Reset, then hold rst=1 for 3 cycles -> ctrl_latch=0, ctrl_clk=0, busy=0, valid=0, data_out=0 with SELECT_controller=1.
- poll_start with pad0 driving pattern 8'b1111_1110 (active-low, A pressed) and pad1 driving all 1s -> busy=1 for 108 cycles, ctrl_latch high 12 cycles, 8 ctrl_clk pulses each 6 high / 6 low. After DONE, addr0 reads 8'h01, addr1 reads 8'h00, valid=1.
- Pad0 driving Right+Start (bits 7,3 low) -> addr0 reads 8'h88. With SELECT_controller=0, data_out=8'h00.
- Read addr0 while a second poll (new pattern 8'h40) is in progress -> returns the old 8'h88 until the cycle after DONE, then 8'h40.
- poll_start pulsed again 20 cycles into a poll -> ignored; exactly one 109-cycle poll occurs. Assert rst at cycle 50 of a poll -> outputs at reset values the next cycle, shadow=0.
- CONTROLLER_DEBOUNCE_EN defined: poll 8'h01 once -> reads 8'h00. Poll 8'h01 again -> reads 8'h01. Poll 8'h02 then 8'h04 -> still 8'h01.
